// File: rtl/scene_sequencer_pkg.sv
// Shared types, scene ROM and speed-to-step helper for the wirecube scene sequencer.
// Attribute encodings here are the contract with the line/fill datapath.
package scene_sequencer_pkg;

  localparam int DEF_PHASE_BITS = 8;

  typedef enum logic [1:0] {AS_SLOW, AS_NORM, AS_FAST, AS_STOP} animation_speed_t;
  typedef enum logic {A_ROTATE, A_BOUNCE} animation_t;
  typedef enum logic {T_NORMAL, T_THICK} thickness_t;
  typedef enum logic {SZ_NORMAL, SZ_SMALL} size_t;
  typedef enum logic [1:0] {BG_COLOR0, BG_COLOR1, BG_STRIPES, BG_SPECIAL} fill_type_t;

  typedef struct packed {
    animation_speed_t speed;
    animation_t       anim;
    thickness_t       thick;
    size_t            size;
    fill_type_t       fill;
  } scene_attr_t;

  function automatic scene_attr_t scene_rom(input logic [1:0] idx);
    scene_attr_t a;
    a = '{AS_NORM, A_ROTATE, T_NORMAL, SZ_NORMAL, BG_COLOR0};
    case (idx)
      2'd0: a = '{AS_NORM, A_ROTATE, T_NORMAL, SZ_NORMAL, BG_COLOR0};
      2'd1: a = '{AS_FAST, A_BOUNCE, T_THICK,  SZ_NORMAL, BG_STRIPES};
      2'd2: a = '{AS_SLOW, A_ROTATE, T_NORMAL, SZ_SMALL,  BG_COLOR1};
      2'd3: a = '{AS_NORM, A_BOUNCE, T_THICK,  SZ_SMALL,  BG_SPECIAL};
      default: ;
    endcase
    return a;
  endfunction

  // Slow speed moves only on odd-parity frames, giving half rate.
  function automatic logic [1:0] step_of(input animation_speed_t speed, input logic parity);
    logic [1:0] s;
    s = 2'd0;
    case (speed)
      AS_SLOW: s = {1'b0, parity};
      AS_NORM: s = 2'd1;
      AS_FAST: s = 2'd2;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scene_sequencer_phase_stepper.sv
// Combinational next-phase / next-direction for rotate (wrapping) and bounce (clamping).
module scene_sequencer_phase_stepper
  import scene_sequencer_pkg::*;
#(
  parameter int PHASE_BITS = DEF_PHASE_BITS
) (
  input  logic [PHASE_BITS-1:0] i_phase,
  input  logic                  i_dir_down,
  input  logic [1:0]            i_step,
  input  animation_t            i_anim,
  output logic [PHASE_BITS-1:0] o_phase,
  output logic                  o_dir_down
);

  localparam logic [PHASE_BITS-1:0] PHASE_MAX = '1;

  logic [PHASE_BITS:0]   w_sum;
  logic [PHASE_BITS-1:0] w_step_ext;

  assign w_step_ext = {{(PHASE_BITS-2){1'b0}}, i_step};
  // One extra bit so the bounce ceiling test sees the carry.
  assign w_sum      = {1'b0, i_phase} + {1'b0, w_step_ext};

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    o_phase    = i_phase;
    o_dir_down = i_dir_down;
    if (i_anim == A_ROTATE) begin
      o_phase = w_sum[PHASE_BITS-1:0];
    end else if (!i_dir_down) begin
      if (w_sum >= {1'b0, PHASE_MAX}) begin
        o_phase    = PHASE_MAX;
        o_dir_down = 1'b1;
      end else begin
        o_phase = w_sum[PHASE_BITS-1:0];
      end
    end else if (i_step != 2'd0) begin
      if (i_phase <= w_step_ext) begin
        o_phase    = '0;
        o_dir_down = 1'b0;
      end else begin
        o_phase = i_phase - w_step_ext;
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-rate controller: steps the animation phase, autoplays scenes and applies
// host overrides, with every attribute change landing on a frame_start_i edge.
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int PHASE_BITS   = DEF_PHASE_BITS,
  parameter int SCENE_FRAMES = 256,
  parameter int NUM_SCENES   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  animation_speed_t              cfg_speed_i,
  input  animation_t                    cfg_anim_i,
  input  thickness_t                    cfg_thick_i,
  input  size_t                         cfg_size_i,
  input  fill_type_t                    cfg_fill_i,
  input  logic                          cfg_hold_i,
  output logic [PHASE_BITS-1:0]         phase_o,
  output animation_speed_t              speed_o,
  output animation_t                    anim_o,
  output thickness_t                    thick_o,
  output size_t                         size_o,
  output fill_type_t                    fill_o,
  output logic [$clog2(NUM_SCENES)-1:0] scene_o,
  output logic                          update_o
);

  localparam int                SCENE_W    = $clog2(NUM_SCENES);
  localparam int                TIMER_W    = $clog2(SCENE_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCENE_FRAMES - 1);

  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_dir_down;
  logic [SCENE_W-1:0]    r_scene;
  scene_attr_t           r_attr;
  logic [TIMER_W-1:0]    r_timer;
  logic                  r_parity;
  logic                  r_hold;
  logic                  r_pending;
  scene_attr_t           r_pend_attr;
  logic                  r_pend_hold;
  logic                  r_update;

  logic [1:0]            w_step;
  logic [PHASE_BITS-1:0] w_phase_next;
  logic                  w_dir_next;
  logic [SCENE_W-1:0]    w_scene_next;
  logic                  w_xfer;

  assign w_step       = step_of(r_attr.speed, r_parity);
  assign w_scene_next = r_scene + 1'b1;
  assign w_xfer       = cfg_valid_i && !r_pending;

  scene_sequencer_phase_stepper #(.PHASE_BITS(PHASE_BITS)) u_stepper (
    .i_phase    (r_phase),
    .i_dir_down (r_dir_down),
    .i_step     (w_step),
    .i_anim     (r_attr.anim),
    .o_phase    (w_phase_next),
    .o_dir_down (w_dir_next)
  );

  // NOTE: non-blocking assignments so every register reads pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= '0;
      r_dir_down  <= 1'b0;
      r_scene     <= '0;
      r_attr      <= scene_rom(2'd0);
      r_timer     <= '0;
      r_parity    <= 1'b0;
      r_hold      <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_attr <= scene_rom(2'd0);
      r_pend_hold <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= frame_start_i;

      if (w_xfer) begin
        r_pend_attr <= '{cfg_speed_i, cfg_anim_i, cfg_thick_i, cfg_size_i, cfg_fill_i};
        r_pend_hold <= cfg_hold_i;
      end

      // A config captured on a frame edge waits for the following frame.
      if (frame_start_i && r_pending) r_pending <= 1'b0;
      else if (w_xfer)                r_pending <= 1'b1;

      if (frame_start_i) begin
        r_parity <= ~r_parity;
        if (r_pending) begin
          r_attr     <= r_pend_attr;
          r_hold     <= r_pend_hold;
          r_timer    <= '0;
          r_phase    <= w_phase_next;
          r_dir_down <= (r_pend_attr.anim == A_ROTATE) ? 1'b0 : w_dir_next;
        end else if (!r_hold && (r_timer == TIMER_LAST)) begin
          r_timer    <= '0;
          r_scene    <= w_scene_next;
          r_attr     <= scene_rom(2'(w_scene_next));
          r_phase    <= '0;
          r_dir_down <= 1'b0;
        end else begin
          r_phase    <= w_phase_next;
          r_dir_down <= w_dir_next;
          if (!r_hold) r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign cfg_ready_o = !r_pending;
  assign phase_o     = r_phase;
  assign speed_o     = r_attr.speed;
  assign anim_o      = r_attr.anim;
  assign thick_o     = r_attr.thick;
  assign size_o      = r_attr.size;
  assign fill_o      = r_attr.fill;
  assign scene_o     = r_scene;
  assign update_o    = r_update;

endmodule

// File: tb/tb_scene_sequencer.sv
// Randomized and directed bench for scene_sequencer against a frame-level reference model.
module tb_scene_sequencer;
  import scene_sequencer_pkg::*;

  localparam int PB  = 8;
  localparam int SF  = 4;
  localparam int NS  = 4;
  localparam int PMX = (1 << PB) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fs;
  logic             cv;
  animation_speed_t cs;
  animation_t       ca;
  thickness_t       ct;
  size_t            cz;
  fill_type_t       cf;
  logic             ch;
  logic             cr;
  logic [PB-1:0]    ph;
  animation_speed_t sp;
  animation_t       an;
  thickness_t       th;
  size_t            sz;
  fill_type_t       fl;
  logic [1:0]       sc;
  logic             up;

  int total = 0;
  int bad   = 0;

  // Reference model state, kept as plain integers and flags.
  int          m_phase, m_scene, m_timer;
  bit          m_down, m_parity, m_hold, m_pending, m_update, m_phold;
  scene_attr_t m_attr, m_pattr;
  scene_attr_t rom [NS];

  scene_sequencer #(.PHASE_BITS(PB), .SCENE_FRAMES(SF), .NUM_SCENES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(fs), .cfg_valid_i(cv), .cfg_ready_o(cr),
    .cfg_speed_i(cs), .cfg_anim_i(ca), .cfg_thick_i(ct), .cfg_size_i(cz), .cfg_fill_i(cf),
    .cfg_hold_i(ch), .phase_o(ph), .speed_o(sp), .anim_o(an), .thick_o(th), .size_o(sz),
    .fill_o(fl), .scene_o(sc), .update_o(up)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [18:0] dut_snap();
    return {ph, sc, sp, an, th, sz, fl, up, cr};
  endfunction

  function automatic logic [18:0] mdl_snap();
    return {8'(m_phase), 2'(m_scene), m_attr, m_update, !m_pending};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_down = 0; m_scene = 0; m_timer = 0; m_parity = 0;
    m_hold = 0; m_pending = 0; m_update = 0; m_attr = rom[0];
  endtask

  task automatic model_frame();
    int st, nph;
    bit nd;
    case (m_attr.speed)
      AS_SLOW: st = m_parity ? 1 : 0;
      AS_NORM: st = 1;
      AS_FAST: st = 2;
      default: st = 0;
    endcase
    nph = m_phase; nd = m_down;
    if (m_attr.anim == A_ROTATE) nph = (m_phase + st) % (PMX + 1);
    else if (!m_down) begin
      if (m_phase + st >= PMX) begin nph = PMX; nd = 1; end
      else nph = m_phase + st;
    end else if (st > 0) begin
      if (m_phase <= st) begin nph = 0; nd = 0; end
      else nph = m_phase - st;
    end
    if (m_pending) begin
      m_attr = m_pattr; m_hold = m_phold; m_timer = 0; m_pending = 0;
      m_phase = nph; m_down = (m_attr.anim == A_ROTATE) ? 1'b0 : nd;
    end else if (!m_hold && m_timer == SF - 1) begin
      m_timer = 0; m_scene = (m_scene + 1) % NS; m_attr = rom[m_scene];
      m_phase = 0; m_down = 0;
    end else begin
      m_phase = nph; m_down = nd;
      if (!m_hold) m_timer = m_timer + 1;
    end
    m_parity = ~m_parity;
  endtask

  // Drives one clock cycle and advances the model to the post-edge state.
  task automatic cyc(input bit f, input bit v, input scene_attr_t a, input bit h);
    bit xfer;
    @(negedge clk);
    fs = f; cv = v; cs = a.speed; ca = a.anim; ct = a.thick; cz = a.size; cf = a.fill; ch = h;
    xfer = v && !m_pending;
    if (f) model_frame();
    if (xfer) begin m_pending = 1; m_pattr = a; m_phold = h; end
    m_update = f;
    @(posedge clk);
    #1;
    fs = 1'b0; cv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fs = 1'b0; cv = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; fs = 1'b0; cv = 1'b0;
    cs = AS_NORM; ca = A_ROTATE; ct = T_NORMAL; cz = SZ_NORMAL; cf = BG_COLOR0; ch = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #10;
    total++; if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL reset_state got=%h exp=%h", dut_snap(), mdl_snap()); end
    total++; if (cr !== 1'b1 || ph !== 8'd0 || up !== 1'b0) begin bad++; $display("FAIL reset_ready got cr=%b ph=%0d up=%b exp cr=1 ph=0 up=0", cr, ph, up); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scene0_frames();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, '0, 0);
      total++; if (ph !== 8'(i + 1) || up !== 1'b1 || sc !== 2'd0 || fl !== BG_COLOR0) begin
        bad++; $display("FAIL scene0_frame%0d got ph=%0d up=%b sc=%0d fl=%0d exp ph=%0d up=1 sc=0 fl=0", i, ph, up, sc, fl, i + 1);
      end
      cyc(0, 0, '0, 0);
      total++; if (up !== 1'b0 || dut_snap() !== mdl_snap()) begin bad++; $display("FAIL scene0_gap%0d got=%h exp=%h", i, dut_snap(), mdl_snap()); end
    end
  endtask

  task automatic test_scene_advance();
    do_reset();
    for (int i = 0; i < SF; i++) cyc(1, 0, '0, 0);
    total++; if (sc !== 2'd1 || ph !== 8'd0 || sp !== AS_FAST || an !== A_BOUNCE) begin
      bad++; $display("FAIL scene_advance got sc=%0d ph=%0d sp=%0d an=%0d exp sc=1 ph=0 sp=2 an=1", sc, ph, sp, an);
    end
    cyc(1, 0, '0, 0);
    total++; if (ph !== 8'd2) begin bad++; $display("FAIL scene1_first_step got ph=%0d exp 2", ph); end
    for (int i = 0; i < 3 * SF; i++) begin
      cyc(1, 0, '0, 0);
      total++; if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL autoplay_f%0d got=%h exp=%h", i, dut_snap(), mdl_snap()); end
    end
  endtask

  task automatic test_bounce();
    int prev;
    bit top_seen, done;
    do_reset();
    cyc(0, 1, '{AS_FAST, A_BOUNCE, T_THICK, SZ_NORMAL, BG_STRIPES}, 1);
    cyc(1, 0, '0, 0);
    top_seen = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      prev = int'(ph);
      cyc(1, 0, '0, 0);
      total++; if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL bounce_f%0d got=%h exp=%h", i, dut_snap(), mdl_snap()); end
      if (!top_seen && prev == PMX - 2) begin
        total++; if (ph !== 8'(PMX)) begin bad++; $display("FAIL bounce_clamp_top got ph=%0d exp %0d", ph, PMX); end
      end
      if (!top_seen && prev == PMX) begin
        top_seen = 1;
        total++; if (ph !== 8'(PMX - 2)) begin bad++; $display("FAIL bounce_turn_down got ph=%0d exp %0d", ph, PMX - 2); end
      end
      if (top_seen && prev == 1) begin
        done = 1;
        total++; if (ph !== 8'd0) begin bad++; $display("FAIL bounce_clamp_bottom got ph=%0d exp 0", ph); end
      end
    end
    if (done) begin
      cyc(1, 0, '0, 0);
      total++; if (ph !== 8'd2 || sc !== 2'd0) begin bad++; $display("FAIL bounce_turn_up got ph=%0d sc=%0d exp ph=2 sc=0", ph, sc); end
    end else begin
      total++; bad++; $display("FAIL bounce_budget got no full bounce within 400 frames exp one");
    end
  endtask

  task automatic test_rotate_slow();
    int start;
    bit hit;
    do_reset();
    cyc(0, 1, '{AS_NORM, A_ROTATE, T_NORMAL, SZ_SMALL, BG_COLOR1}, 1);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc(1, 0, '0, 0);
      if (ph === 8'(PMX)) hit = 1;
    end
    total++; if (!hit || dut_snap() !== mdl_snap()) begin bad++; $display("FAIL rotate_reach_max got ph=%0d exp %0d", ph, PMX); end
    cyc(1, 0, '0, 0);
    total++; if (ph !== 8'd0) begin bad++; $display("FAIL rotate_wrap got ph=%0d exp 0", ph); end
    cyc(0, 1, '{AS_SLOW, A_ROTATE, T_NORMAL, SZ_NORMAL, BG_COLOR0}, 1);
    cyc(1, 0, '0, 0);
    start = int'(ph);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, '0, 0);
      total++; if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL slow_f%0d got=%h exp=%h", i, dut_snap(), mdl_snap()); end
    end
    total++; if (int'(ph) - start !== 4) begin bad++; $display("FAIL slow_rate got advance=%0d exp 4", int'(ph) - start); end
  endtask

  task automatic test_handshake();
    scene_attr_t a, b;
    a = '{AS_FAST, A_ROTATE, T_THICK, SZ_SMALL, BG_STRIPES};
    b = '{AS_STOP, A_BOUNCE, T_NORMAL, SZ_NORMAL, BG_SPECIAL};
    do_reset();
    cyc(1, 1, a, 1);
    total++; if (cr !== 1'b0 || sp !== AS_NORM || fl !== BG_COLOR0 || ph !== 8'd1) begin
      bad++; $display("FAIL hs_same_frame got cr=%b sp=%0d fl=%0d ph=%0d exp cr=0 sp=1 fl=0 ph=1", cr, sp, fl, ph);
    end
    cyc(0, 1, b, 0);
    total++; if (cr !== 1'b0) begin bad++; $display("FAIL hs_pending_ready got cr=%b exp 0", cr); end
    cyc(1, 0, '0, 0);
    total++; if ({sp, an, th, sz, fl} !== a || cr !== 1'b1 || ph !== 8'd2) begin
      bad++; $display("FAIL hs_apply got attr=%h cr=%b ph=%0d exp attr=%h cr=1 ph=2", {sp, an, th, sz, fl}, cr, ph, a);
    end
    for (int i = 0; i < 2 * SF; i++) cyc(1, 0, '0, 0);
    total++; if ({sp, an, th, sz, fl} !== a || sc !== 2'd0 || dut_snap() !== mdl_snap()) begin
      bad++; $display("FAIL hs_hold got=%h exp=%h", dut_snap(), mdl_snap());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    cyc(0, 1, '{AS_FAST, A_BOUNCE, T_THICK, SZ_SMALL, BG_SPECIAL}, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (dut_snap() !== mdl_snap() || cr !== 1'b1 || ph !== 8'd0) begin
      bad++; $display("FAIL reset_mid got=%h exp=%h", dut_snap(), mdl_snap());
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, '0, 0);
    total++; if (sp !== AS_NORM || an !== A_ROTATE || fl !== BG_COLOR0 || ph !== 8'd1 || sc !== 2'd0) begin
      bad++; $display("FAIL reset_discard got sp=%0d an=%0d fl=%0d ph=%0d sc=%0d exp sp=1 an=0 fl=0 ph=1 sc=0", sp, an, fl, ph, sc);
    end
  endtask

  task automatic test_random();
    scene_attr_t a;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      a = scene_attr_t'(7'($urandom_range(0, 127)));
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), a, $urandom_range(0, 1) == 1);
      total++; if (dut_snap() !== mdl_snap()) begin bad++; $display("FAIL random_c%0d got=%h exp=%h", i, dut_snap(), mdl_snap()); end
    end
  endtask

  initial begin
    rom[0] = '{AS_NORM, A_ROTATE, T_NORMAL, SZ_NORMAL, BG_COLOR0};
    rom[1] = '{AS_FAST, A_BOUNCE, T_THICK,  SZ_NORMAL, BG_STRIPES};
    rom[2] = '{AS_SLOW, A_ROTATE, T_NORMAL, SZ_SMALL,  BG_COLOR1};
    rom[3] = '{AS_NORM, A_BOUNCE, T_THICK,  SZ_SMALL,  BG_SPECIAL};
    test_reset();
    test_scene0_frames();
    test_scene_advance();
    test_bounce();
    test_rotate_slow();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Frame-rate controller for the wirecube renderer.
- Advances a per-frame animation phase according to speed and animation mode (rotate/bounce).
- Autoplays a fixed list of attribute scenes and accepts host overrides through a valid/ready handshake.
- Sits between the VGA timing generator (frame_start) and the line/fill datapath. All attribute changes land only at frame boundaries.

Parameters:
- PHASE_BITS, 8: width of the animation phase; PHASE_MAX = 2^PHASE_BITS-1.
- SCENE_FRAMES, 256: frames per autoplay scene, ≥2.
- NUM_SCENES, 4: entries in the scene ROM, power of two.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start_i  in  1  one-cycle pulse at the start of vertical blank
- cfg_valid_i  in  1  host config request
- cfg_ready_o  out  1  config slot free
- cfg_speed_i  in  2  animation_speed_t
- cfg_anim_i  in  1  animation_t
- cfg_thick_i  in  1  thickness_t
- cfg_size_i  in  1  size_t
- cfg_fill_i  in  2  fill_type_t
- cfg_hold_i  in  1  1 = freeze autoplay after apply; 0 = resume autoplay
- phase_o  out  PHASE_BITS  animation phase
- speed_o, anim_o, thick_o, size_o, fill_o  out  2/1/1/1/2  active attributes
- scene_o  out  $clog2(NUM_SCENES)  current scene index
- update_o  out  1  one-cycle pulse, cycle after each frame_start_i

Behaviour:
Reset values:
- phase_o=0, direction=up, scene_o=0, attributes=SCENE_ROM[0].
- Frame timer=0, frame parity=0, pending=0, hold=0, cfg_ready_o=1, update_o=0.

Frame update:
- All state updates on the clock edge where frame_start_i=1; outputs are registered, so latency is 1 cycle.
- update_o=1 in the cycle after each frame_start_i. Back-to-back pulses are each processed.

Frame parity:
- Toggles on every frame_start_i.

Step, computed from attributes in effect before the edge:
- AS_SLOW: 1 when parity=1, else 0.
- AS_NORM: 1.
- AS_FAST: 2.
- AS_STOP: 0.

A_ROTATE:
- phase = (phase + step) mod 2^PHASE_BITS, wrapping.

A_BOUNCE, up:
- If phase + step ≥ PHASE_MAX: phase = PHASE_MAX and direction = down.
- Otherwise phase += step.

A_BOUNCE, down:
- If phase ≤ step: phase = 0 and direction = up.
- Otherwise phase -= step.
- Applies only when step>0.

Scene timer, when hold=0:
- Increments each frame.
- At SCENE_FRAMES-1 the timer wraps to 0, scene = (scene+1) mod NUM_SCENES, attributes = SCENE_ROM[scene], phase = 0, direction = up.
- The scene reset overrides the step.
- When hold=1 the timer is frozen.

Config handshake:
- Transfer when cfg_valid_i && cfg_ready_o. Inputs are captured into the pending register, pending=1, cfg_ready_o=0.
- cfg_ready_o = !pending.

Applying pending config at frame_start_i:
- Attributes = pending, hold = cfg_hold, timer = 0, pending = 0 (cfg_ready_o=1 next cycle).
- Priority over scene advance in the same frame; the scene index is unchanged.
- phase_o is retained after the step.
- Direction is forced up if the new anim is A_ROTATE.

Simultaneous events and edge cases:
- Transfer and frame_start_i in the same cycle with pending=0: the config is captured but applied at the next frame_start_i, not this one.
- cfg_valid_i while pending=1: ignored, no transfer.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); a pending config is discarded.

Decomposition:
Shared package:
- scene_attr_t packed struct {animation_speed_t speed; animation_t anim; thickness_t thick; size_t size; fill_type_t fill}.
- SCENE_ROM constant:
  - [0] NORM/ROTATE/NORMAL/NORMAL/COLOR0
  - [1] FAST/BOUNCE/THICK/NORMAL/STRIPES
  - [2] SLOW/ROTATE/NORMAL/SMALL/COLOR1
  - [3] NORM/BOUNCE/THICK/SMALL/SPECIAL
- PHASE_BITS default.

Sub-module:
- phase_stepper: combinational next-phase/next-direction from phase, dir, step, anim. Keeps bounce clamping testable in isolation.

Test Plan:
1. Reset, then 3 frame_start pulses in scene 0 → phase_o 1,2,3; update_o pulses 1 cycle after each; scene_o=0, fill_o=BG_COLOR0.
2. SCENE_FRAMES=4, 4 frames → after the 4th, scene_o=1, phase_o=0, speed_o=AS_FAST, anim_o=A_BOUNCE. Next frame phase_o=2.
3. Bounce: config FAST/BOUNCE with hold=1, force phase to 254 via frames from 0 → sequence …252,254,255(dir down),253,251. From phase 1 down, next → 0 with dir up.
4. Rotate wrap: NORM/ROTATE hold, phase 255 → next frame 0. SLOW: phase advances only on odd-parity frames (0,0,1,1,2 pattern offset by parity).
5. Handshake: cfg_valid with frame_start in the same cycle → cfg_ready_o=0, attributes unchanged at that frame, applied at the next frame. Second cfg_valid while pending is ignored (original value applied).
6. Async reset asserted mid-frame with a pending config → all outputs at reset values, cfg_ready_o=1; the discarded config is never applied.
